// File: rtl/nios2_key_debounce.sv
// Debounce and conditioning stage for the Nios II key PIO: synchronises active-low
// push-button pins and produces a clean active-high level plus press/release pulses.
module nios2_key_debounce #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser flops hold raw pin polarity, so reset to 1 means "released".
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync = ~r_sync2;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_state   <= ST_RELEASED;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        // NOTE: the default arm recovers from unreachable encodings; all four
        // states are covered so no state can linger in an undefined value.
        case (r_state)
          ST_RELEASED: begin
            r_cnt <= '0;
            if (w_sync[k]) r_state <= ST_PRESS_WAIT;
          end
          ST_PRESS_WAIT: begin
            if (!w_sync[k]) begin
              r_state <= ST_RELEASED;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= ST_PRESSED;
              r_level <= 1'b1;
              r_press <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_PRESSED: begin
            r_cnt <= '0;
            if (!w_sync[k]) r_state <= ST_RELEASE_WAIT;
          end
          ST_RELEASE_WAIT: begin
            if (w_sync[k]) begin
              r_state <= ST_PRESSED;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state   <= ST_RELEASED;
              r_level   <= 1'b0;
              r_release <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end
        endcase
      end
    end

    assign key_level[k]   = r_level;
    assign key_press[k]   = r_press;
    assign key_release[k] = r_release;
  end

endmodule

// File: tb/tb_nios2_key_debounce.sv
// Directed scoreboard bench: expected {level,press,release} per cycle is queued
// with the stimulus and popped against the DUT on each falling edge.
module tb_nios2_key_debounce;

  logic       clk;
  logic       reset_n;
  logic [2:0] key_raw_a, key_raw_b;
  logic [2:0] lvl_a, prs_a, rel_a;
  logic [2:0] lvl_b, prs_b, rel_b;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    bit         sel;
    logic [8:0] exp;
  } exp_t;

  exp_t sb_q[$];

  nios2_key_debounce #(.NUM_KEYS(3), .DEBOUNCE_CYCLES(8), .CNT_W(20)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw_a),
    .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a)
  );

  nios2_key_debounce #(.NUM_KEYS(3), .DEBOUNCE_CYCLES(16), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw_b),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b)
  );

  always #5 clk = ~clk;

  task automatic push_n(input string tag, input bit sel, input int n,
                        input logic [2:0] l, input logic [2:0] p, input logic [2:0] r);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.sel = sel;
      e.exp = {l, p, r};
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    exp_t       e;
    logic [8:0] obs;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e   = sb_q.pop_front();
      obs = e.sel ? {lvl_b, prs_b, rel_b} : {lvl_a, prs_a, rel_a};
      n_cmp++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed lvl/prs/rel=%b required %b", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    clk       = 1'b0;
    reset_n   = 1'b0;
    key_raw_a = 3'b111;
    key_raw_b = 3'b111;
    push_n("reset_a", 0, 2, 3'b000, 3'b000, 3'b000);
    push_n("reset_b", 1, 1, 3'b000, 3'b000, 3'b000);
    drain();
    reset_n = 1'b1;

    // Clean press on key 0: accepted at edge 11, pulse gone at edge 12.
    key_raw_a = 3'b110;
    push_n("press0_wait",  0, 10, 3'b000, 3'b000, 3'b000);
    push_n("press0_edge",  0, 1,  3'b001, 3'b001, 3'b000);
    push_n("press0_hold",  0, 4,  3'b001, 3'b000, 3'b000);
    drain();

    // Release key 0.
    key_raw_a = 3'b111;
    push_n("rel0_wait", 0, 10, 3'b001, 3'b000, 3'b000);
    push_n("rel0_edge", 0, 1,  3'b000, 3'b000, 3'b001);
    push_n("rel0_hold", 0, 3,  3'b000, 3'b000, 3'b000);
    drain();

    // Bounce on key 1: low 5, high 2, low 5, high -> nothing accepted.
    key_raw_a = 3'b101;
    push_n("bounce_a", 0, 5, 3'b000, 3'b000, 3'b000);
    drain();
    key_raw_a = 3'b111;
    push_n("bounce_b", 0, 2, 3'b000, 3'b000, 3'b000);
    drain();
    key_raw_a = 3'b101;
    push_n("bounce_c", 0, 5, 3'b000, 3'b000, 3'b000);
    drain();
    key_raw_a = 3'b111;
    push_n("bounce_d", 0, 12, 3'b000, 3'b000, 3'b000);
    drain();

    // Key 1 held low 20 cycles: one press 11 edges after the falling sample.
    key_raw_a = 3'b101;
    push_n("press1_wait", 0, 10, 3'b000, 3'b000, 3'b000);
    push_n("press1_edge", 0, 1,  3'b010, 3'b010, 3'b000);
    push_n("press1_hold", 0, 9,  3'b010, 3'b000, 3'b000);
    drain();
    key_raw_a = 3'b111;
    push_n("rel1_wait", 0, 10, 3'b010, 3'b000, 3'b000);
    push_n("rel1_edge", 0, 1,  3'b000, 3'b000, 3'b010);
    push_n("rel1_hold", 0, 2,  3'b000, 3'b000, 3'b000);
    drain();

    // Simultaneous press of all keys, then release only key 2.
    key_raw_a = 3'b000;
    push_n("all_wait", 0, 10, 3'b000, 3'b000, 3'b000);
    push_n("all_edge", 0, 1,  3'b111, 3'b111, 3'b000);
    push_n("all_hold", 0, 2,  3'b111, 3'b000, 3'b000);
    drain();
    key_raw_a = 3'b100;
    push_n("k2rel_wait", 0, 10, 3'b111, 3'b000, 3'b000);
    push_n("k2rel_edge", 0, 1,  3'b011, 3'b000, 3'b100);
    push_n("k2rel_hold", 0, 2,  3'b011, 3'b000, 3'b000);
    drain();
    key_raw_a = 3'b111;
    push_n("allrel_wait", 0, 10, 3'b011, 3'b000, 3'b000);
    push_n("allrel_edge", 0, 1,  3'b000, 3'b000, 3'b011);
    push_n("allrel_hold", 0, 2,  3'b000, 3'b000, 3'b000);
    drain();

    // Reset during PRESS_WAIT (cnt = 6 after edge 9), key 0 kept low.
    key_raw_a = 3'b110;
    push_n("rstmid_pre", 0, 9, 3'b000, 3'b000, 3'b000);
    drain();
    reset_n = 1'b0;
    push_n("rstmid_rst", 0, 1, 3'b000, 3'b000, 3'b000);
    drain();
    reset_n = 1'b1;
    push_n("rstmid_wait", 0, 10, 3'b000, 3'b000, 3'b000);
    push_n("rstmid_edge", 0, 1,  3'b001, 3'b001, 3'b000);
    push_n("rstmid_hold", 0, 2,  3'b001, 3'b000, 3'b000);
    drain();

    // Maximum count on the CNT_W=4 instance: accepted at edge 19, not earlier.
    key_raw_b = 3'b110;
    push_n("max_wait", 1, 18, 3'b000, 3'b000, 3'b000);
    push_n("max_edge", 1, 1,  3'b001, 3'b001, 3'b000);
    push_n("max_hold", 1, 3,  3'b001, 3'b000, 3'b000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
